// File: rtl/framebuffer_scanout.sv
// VGA scanout for a half-resolution framebuffer: each framebuffer pixel is shown as a 2x2 block.
// The pixel clock is every second system clock; all outputs are registered one pixel behind the counters.
module framebuffer_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int FB_WIDTH  = 320
) (
   input  logic        clock,
   input  logic        reset,
   output logic [16:0] mem_addr,
   input  logic [2:0]  mem_data,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        frame_start
);
   localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VISIBLE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);

   logic          tick_q;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [7:0]    r_q, g_q, b_q;
   logic          hs_q, vs_q, blank_n_q, fs_q;
   logic          h_vis, v_vis, vis, hs_d, vs_d;
   logic [16:0]   addr_d;

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (tick_q) begin
         if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
         end else begin
            h_d = h_q + HW'(1);
         end
      end
   end

   assign h_vis = h_q < HW'(H_VISIBLE);
   assign v_vis = v_q < VW'(V_VISIBLE);
   assign vis   = h_vis && v_vis;
   assign hs_d  = !((h_q >= HW'(HS_START)) && (h_q < HW'(HS_END)));
   assign vs_d  = !((v_q >= VW'(VS_START)) && (v_q < VW'(VS_END)));

   // Address tracks the live counters so the one-clock memory latency lands before the next tick.
   always_comb begin
      addr_d = '0;
      if (vis) addr_d = 17'(v_q >> 1) * 17'(FB_WIDTH) + 17'(h_q >> 1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_q    <= 1'b0;
         h_q       <= '0;
         v_q       <= '0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         tick_q <= ~tick_q;
         h_q    <= h_d;
         v_q    <= v_d;
         fs_q   <= tick_q && (h_q == '0) && (v_q == '0);
         if (tick_q) begin
            r_q       <= {8{mem_data[2] & vis}};
            g_q       <= {8{mem_data[1] & vis}};
            b_q       <= {8{mem_data[0] & vis}};
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= vis;
         end
      end
   end

   assign mem_addr    = addr_d;
   assign vga_r       = r_q;
   assign vga_g       = g_q;
   assign vga_b       = b_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;
   assign frame_start = fs_q;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout on a shrunken raster (25x13 ticks per frame).
module tb_framebuffer_scanout;
   localparam int HV = 16, HF = 2, HS = 4, HB = 3;
   localparam int VV = 8, VF = 1, VS = 2, VB = 2;
   localparam int FBW  = 8;
   localparam int HT   = HV + HF + HS + HB;   // 25
   localparam int VT   = VV + VF + VS + VB;   // 13
   localparam int FT   = HT * VT;             // 325 ticks = 650 clocks per frame
   localparam int MAXA = 31;                  // (7>>1)*8 + (15>>1)

   typedef struct packed {
      logic [7:0]  r, g, b;
      logic        hs, vs, bn, fs;
      logic [16:0] addr;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic [16:0] mem_addr;
   logic [2:0]  mem_data = 3'b000;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n, frame_start;

   bit   mode = 1'b0;
   bit   active = 1'b0;
   int   run_id = 0;
   int   pe = 0;
   int   max_addr = 0;
   int   n_cmp = 0, n_bad = 0;
   exp_t q[$];

   framebuffer_scanout #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FB_WIDTH(FBW)
   ) dut (
      .clock(clock), .reset(rst_n), .mem_addr(mem_addr), .mem_data(mem_data),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   // Framebuffer: one-clock read latency, colour = addr[2:0] or constant white.
   always @(posedge clock) mem_data <= mode ? 3'b111 : mem_addr[2:0];

   // Clock edges since reset release.
   always @(posedge clock or negedge rst_n)
      if (!rst_n) pe <= 0;
      else        pe <= pe + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [16:0] addr_of(input int h, input int v);
      if (h < HV && v < VV) return 17'((v / 2) * FBW + h / 2);
      return 17'd0;
   endfunction

   function automatic exp_t model(input int k, input bit m);
      exp_t        e;
      int          h, v, h1, v1;
      logic [16:0] a;
      logic [2:0]  col;
      bit          vis;
      h   = k % HT;
      v   = (k / HT) % VT;
      h1  = (k + 1) % HT;
      v1  = ((k + 1) / HT) % VT;
      vis = (h < HV) && (v < VV);
      a   = addr_of(h, v);
      col = m ? 3'b111 : a[2:0];
      e.r    = (vis && col[2]) ? 8'hFF : 8'h00;
      e.g    = (vis && col[1]) ? 8'hFF : 8'h00;
      e.b    = (vis && col[0]) ? 8'hFF : 8'h00;
      e.hs   = !(h >= HV + HF && h < HV + HF + HS);
      e.vs   = !(v >= VV + VF && v < VV + VF + VS);
      e.bn   = vis;
      e.fs   = (k % FT) == 0;
      e.addr = addr_of(h1, v1);
      return e;
   endfunction

   // Monitor: a pixel is presented after every tick edge (even edge count >= 2).
   always @(negedge clock) begin
      exp_t e, got;
      int   k;
      if (rst_n && active) begin
         if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
         if (pe == 1) begin
            check("first_tick_not_yet", {vga_blank_n, vga_hs, vga_vs, frame_start, vga_r, vga_g, vga_b},
                  {1'b0, 1'b1, 1'b1, 1'b0, 24'h0});
         end else if (pe >= 2 && (pe % 2) == 0) begin
            if (q.size() > 0) begin
               e   = q.pop_front();
               k   = (pe - 2) / 2;
               got = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, mem_addr};
               check($sformatf("run%0d_pix%0d", run_id, k), got, e);
               // Pixels (4,2),(5,2),(4,3),(5,3) all read addr 10 = 3'b010 -> green only.
               if (run_id == 1 && (k == 2*HT+4 || k == 2*HT+5 || k == 3*HT+4 || k == 3*HT+5))
                  check($sformatf("block2x2_pix%0d", k), {vga_r, vga_g, vga_b}, 24'h00FF00);
            end
         end else if (pe >= 3) begin
            check($sformatf("run%0d_fs_one_clock_e%0d", run_id, pe), frame_start, 1'b0);
         end
      end
   end

   task automatic run(input int n, input int rid, input bit m);
      int t;
      q.delete();
      mode   = m;
      run_id = rid;
      for (int k = 0; k < n; k++) q.push_back(model(k, m));
      @(negedge clock);
      active = 1'b1;
      rst_n  = 1'b1;
      t = 0;
      while (q.size() > 0 && t < 2 * n + 20) begin
         @(negedge clock);
         t++;
      end
      if (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL run%0d_timeout: got %0d pending want 0", rid, q.size());
      end
   endtask

   task automatic check_reset_vals(input string nm);
      check(nm, {mem_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start},
            {17'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0});
   endtask

   initial begin
      repeat (4) @(negedge clock);
      check_reset_vals("reset_values");

      // Two full frames of addr-coloured data, including the 324->0 frame wrap.
      run(2 * FT + 1, 1, 1'b0);
      check("max_addr", max_addr, MAXA);
      @(posedge clock); #2;
      rst_n = 1'b0; active = 1'b0;
      #1 check_reset_vals("reset_after_run1");
      repeat (2) @(posedge clock);

      // Stop with counters at (10,5), then hit reset between clock edges.
      run(5 * HT + 10, 2, 1'b0);
      #2;
      rst_n = 1'b0; active = 1'b0;
      #1 check_reset_vals("async_reset_midline");
      repeat (3) @(posedge clock);
      #1 check_reset_vals("held_in_reset");

      // Restart: frame_start again at k=0 and one full frame later.
      run(FT + 2, 3, 1'b0);
      @(posedge clock); #2;
      rst_n = 1'b0; active = 1'b0;
      repeat (2) @(posedge clock);

      // Constant white memory: colour must be zero throughout blanking.
      run(FT + 1, 4, 1'b1);
      check("max_addr_final", max_addr, MAXA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
